// File: rtl/matmul_ctrl.sv
// Control FSM for the matrix-multiply datapath: operand load, MAC sequencing and C write-back.
// Optional feature macro MATMUL_CTRL_READBACK_EN adds a mat3 readback pass (READ) before DONE.
module matmul_ctrl #(
  parameter int unsigned M      = 8,
  parameter int unsigned N      = 8,
  parameter int unsigned ADDR_W = 16,
  parameter logic [1:0]  SHIFT  = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              m1EN,
  output logic              m1rEN,
  output logic              m1wEN,
  output logic              m2EN,
  output logic              m2rEN,
  output logic              m2wEN,
  output logic              m3EN,
  output logic              m3rEN,
  output logic              m3wEN,
  output logic              mult_ld,
  output logic              mult_rst,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [1:0]        shift_cnt
`ifdef MATMUL_CTRL_READBACK_EN
  ,
  output logic              out_valid
`endif
);

  localparam int unsigned MW       = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LD_WORDS = M * N;
  localparam int unsigned LW       = (LD_WORDS > 1) ? $clog2(LD_WORDS) : 1;
`ifdef MATMUL_CTRL_READBACK_EN
  localparam int unsigned RB_WORDS = M * M;
  localparam int unsigned RW       = (RB_WORDS > 1) ? $clog2(RB_WORDS) : 1;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CLR,
    S_MAC,
    S_TAIL,
    S_WB,
`ifdef MATMUL_CTRL_READBACK_EN
    S_READ,
    S_DRAIN,
`endif
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  ld_q, ld_d;
  logic [MW-1:0]  i_q, i_d, j_q, j_d;
  logic [NW-1:0]  k_q, k_d;
  logic           rd_issue;
`ifdef MATMUL_CTRL_READBACK_EN
  logic [RW-1:0]  rb_q, rb_d;
  logic           rb_issue;
`endif

  assign shift_cnt = SHIFT;

  // State, counters and the one-cycle-delayed read strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      mult_ld <= 1'b0;
`ifdef MATMUL_CTRL_READBACK_EN
      rb_q      <= '0;
      out_valid <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mult_ld <= rd_issue;
`ifdef MATMUL_CTRL_READBACK_EN
      rb_q      <= rb_d;
      out_valid <= rb_issue;
`endif
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    rd_issue = 1'b0;
    in_ready = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    m1EN     = 1'b0;
    m1rEN    = 1'b0;
    m1wEN    = 1'b0;
    m2EN     = 1'b0;
    m2rEN    = 1'b0;
    m2wEN    = 1'b0;
    m3EN     = 1'b0;
    m3rEN    = 1'b0;
    m3wEN    = 1'b0;
    mult_rst = 1'b0;
    addr1    = '0;
    addr2    = '0;
    addr3    = '0;
`ifdef MATMUL_CTRL_READBACK_EN
    rb_d     = rb_q;
    rb_issue = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          ld_d    = '0;
        end
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m1EN  = 1'b1;
          m1wEN = 1'b1;
          addr1 = ADDR_W'(ld_q);
          if (ld_q == LW'(LD_WORDS - 1)) begin
            ld_d    = '0;
            state_d = S_LOAD_B;
          end else begin
            ld_d = ld_q + LW'(1);
          end
        end
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m2EN  = 1'b1;
          m2wEN = 1'b1;
          addr2 = ADDR_W'(ld_q);
          if (ld_q == LW'(LD_WORDS - 1)) begin
            ld_d    = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = S_CLR;
          end else begin
            ld_d = ld_q + LW'(1);
          end
        end
      end
      S_CLR: begin
        mult_rst = 1'b1;
        k_d      = '0;
        state_d  = S_MAC;
      end
      S_MAC: begin
        rd_issue = 1'b1;
        m1EN     = 1'b1;
        m1rEN    = 1'b1;
        m2EN     = 1'b1;
        m2rEN    = 1'b1;
        addr1    = ADDR_W'(32'(i_q) * N + 32'(k_q));
        addr2    = ADDR_W'(32'(k_q) * M + 32'(j_q));
        if (k_q == NW'(N - 1)) begin
          k_d     = '0;
          state_d = S_TAIL;
        end else begin
          k_d = k_q + NW'(1);
        end
      end
      S_TAIL: state_d = S_WB;
      S_WB: begin
        m3EN  = 1'b1;
        m3wEN = 1'b1;
        addr3 = ADDR_W'(32'(i_q) * M + 32'(j_q));
        if (j_q == MW'(M - 1)) begin
          j_d = '0;
          if (i_q == MW'(M - 1)) begin
            i_d = '0;
`ifdef MATMUL_CTRL_READBACK_EN
            rb_d    = '0;
            state_d = S_READ;
`else
            state_d = S_DONE;
`endif
          end else begin
            i_d     = i_q + MW'(1);
            state_d = S_CLR;
          end
        end else begin
          j_d     = j_q + MW'(1);
          state_d = S_CLR;
        end
      end
`ifdef MATMUL_CTRL_READBACK_EN
      S_READ: begin
        rb_issue = 1'b1;
        m3EN     = 1'b1;
        m3rEN    = 1'b1;
        addr3    = ADDR_W'(rb_q);
        if (rb_q == RW'(RB_WORDS - 1)) begin
          rb_d    = '0;
          state_d = S_DRAIN;
        end else begin
          rb_d = rb_q + RW'(1);
        end
      end
      // Last readback word is on data_out this cycle; DONE comes after it
      S_DRAIN: state_d = S_DONE;
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl (M=2, N=3) with a behavioural operand/accumulator datapath attached.
module tb_matmul_ctrl;
  localparam int unsigned M    = 2;
  localparam int unsigned N    = 3;
  localparam int unsigned AW   = 8;
  localparam int unsigned MN   = M * N;
  localparam int unsigned MM   = M * M;
  localparam logic [1:0]  SH   = 2'b10;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic in_ready, busy, done, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN;
  logic m3EN, m3rEN, m3wEN, mult_ld, mult_rst;
  logic [AW-1:0] addr1, addr2, addr3;
  logic [1:0] shift_cnt;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int exp_c[MM];
  int cur_a[MN], cur_b[MN];

  always #5 clk = ~clk;

  matmul_ctrl #(.M(M), .N(N), .ADDR_W(AW), .SHIFT(SH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done),
    .m1EN(m1EN), .m1rEN(m1rEN), .m1wEN(m1wEN),
    .m2EN(m2EN), .m2rEN(m2rEN), .m2wEN(m2wEN),
    .m3EN(m3EN), .m3rEN(m3rEN), .m3wEN(m3wEN),
    .mult_ld(mult_ld), .mult_rst(mult_rst),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .shift_cnt(shift_cnt)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int strobes();
    return int'({in_ready, busy, done, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN,
                 m3EN, m3rEN, m3wEN, mult_ld, mult_rst});
  endfunction

  // Datapath stand-in: synchronous memories and accumulator
  int mem1[MN], mem2[MN];
  int out1 = 0, out2 = 0, acc = 0;
  always @(posedge clk) begin
    if (m1EN && m1wEN && int'(addr1) < MN) mem1[int'(addr1)] <= int'(data_in);
    if (m2EN && m2wEN && int'(addr2) < MN) mem2[int'(addr2)] <= int'(data_in);
    if (m1EN && m1rEN && int'(addr1) < MN) out1 <= mem1[int'(addr1)];
    if (m2EN && m2rEN && int'(addr2) < MN) out2 <= mem2[int'(addr2)];
    if (mult_rst) acc <= 0;
    else if (mult_ld) acc <= acc + out1 * out2;
  end

  // Protocol monitor: load addresses, MAC addressing, strobe alignment, write-back, done timing
  int wb_idx = 0, ld1 = 0, ld2 = 0, mac_k = 0, nrst = 0, nld = 0, last_acc = 0;
  logic prev_rd = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst) begin
      wb_idx = 0; ld1 = 0; ld2 = 0; mac_k = 0; nrst = 0; nld = 0;
      prev_rd = 1'b0; prev_done = 1'b0;
    end else begin
      if (start && !busy) begin
        wb_idx = 0; ld1 = 0; ld2 = 0; mac_k = 0; nrst = 0; nld = 0;
      end
      if (in_valid && in_ready) last_acc = cyc;
      if (m1wEN) begin
        check("load_addr1", int'(addr1), ld1);
        check("load_valid1", int'(in_valid && m1EN), 1);
        check("load_count1", int'(ld1 < MN), 1);
        ld1++;
      end
      if (m2wEN) begin
        check("load_addr2", int'(addr2), ld2);
        check("load_valid2", int'(in_valid && m2EN), 1);
        check("a_before_b", ld1, MN);
        ld2++;
      end
      if (busy) check("mult_ld_align", int'(mult_ld), int'(prev_rd));
      if (mult_rst) begin nrst++; nld = 0; mac_k = 0; end
      if (mult_ld) nld++;
      if (m1rEN) begin
        check("mac_addr1", int'(addr1), (wb_idx / M) * N + mac_k);
        check("mac_addr2", int'(addr2), mac_k * M + wb_idx % M);
        check("mac_strobes", int'({m1EN, m2EN, m2rEN}), 7);
        mac_k++;
      end
      if (m3wEN) begin
        check("wb_addr3", int'(addr3), wb_idx);
        check("wb_data", acc, (wb_idx < MM) ? exp_c[wb_idx] : -1);
        check("wb_mult_ld_cycles", nld, N);
        check("wb_mult_rst_pulses", nrst, 1);
        check("wb_mac_depth", mac_k, N);
        nrst = 0;
        wb_idx++;
      end
      if (done) begin
        check("done_latency", cyc - last_acc, 1 + MM * (N + 3));
        check("done_wb_count", wb_idx, MM);
        check("done_width", int'(prev_done), 0);
      end
      prev_rd   = m1rEN;
      prev_done = done;
    end
  end

  // One job: mode 0 = continuous in_valid, 1 = toggling, 2 = random; abort resets mid-MAC of C[1][0]
  task automatic run_job(input int mode, input bit abort);
    int idx, cycle;
    bit got_done;
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    idx = 0; cycle = 0;
    while (idx < 2 * MN && cycle < 1000) begin
      if (cycle != 0) @(negedge clk);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cycle % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      data_in = 8'((idx < MN) ? cur_a[idx] : cur_b[idx - MN]);
      start   = (idx == MN + 1);
      #1;
      if (cycle == 0) begin
        check("start_latency_ready", int'(in_ready), 1);
        check("busy_after_start", int'(busy), 1);
      end
      if (in_valid && in_ready) idx++;
      cycle++;
    end
    start = 1'b0;
    if (idx < 2 * MN) check("load_timeout", idx, 2 * MN);
    got_done = 1'b0;
    for (int w = 0; w < 2000 && !got_done; w++) begin
      @(negedge clk);
      in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      start    = (w == 3);
      #1;
      if (abort && m1rEN && int'(addr1) == N && int'(addr2) == 0) begin
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        #1;
        check("abort_strobes", strobes(), 0);
        check("abort_addrs", int'({addr1, addr2, addr3}), 0);
        check("abort_shift", int'(shift_cnt), int'(SH));
        for (int q = 0; q < 40; q++) begin
          @(negedge clk); #1;
          if (done || busy) begin
            check("abort_quiet", int'({done, busy}), 0);
            break;
          end
        end
        return;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    if (!got_done) begin
      check("done_timeout", 0, 1);
    end else begin
      start = 1'b1;
      @(negedge clk); start = 1'b0; in_valid = 1'b0;
      #1;
      check("after_done_idle", int'({busy, done, in_ready}), 0);
    end
  endtask

  function automatic void ref_matmul();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        exp_c[i * M + j] = 0;
        for (int k = 0; k < N; k++)
          exp_c[i * M + j] += cur_a[i * N + k] * cur_b[k * M + j];
      end
  endfunction

  typedef struct packed {
    logic [MN-1:0][7:0]  a;
    logic [MN-1:0][7:0]  b;
    logic [MM-1:0][31:0] c;
    logic [1:0]          mode;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0].a = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].b = {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7};
    tbl[0].c = {32'd154, 32'd139, 32'd64, 32'd58};
    tbl[0].mode = 2'd0;
    tbl[1] = tbl[0];
    tbl[1].mode = 2'd1;
    tbl[2].a = {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    tbl[2].b = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    tbl[2].c = {32'd5, 32'd4, 32'd3, 32'd2};
    tbl[2].mode = 2'd1;
    tbl[3].a = {MN{8'hFF}};
    tbl[3].b = {MN{8'hFF}};
    tbl[3].c = {MM{32'd195075}};
    tbl[3].mode = 2'd0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_strobes", strobes(), 0);
    check("reset_addrs", int'({addr1, addr2, addr3}), 0);
    check("reset_shift", int'(shift_cnt), int'(SH));
    @(negedge clk); rst = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_ignores_valid", int'({in_ready, m1wEN, m2wEN, busy}), 0);
    end
    in_valid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int x = 0; x < MN; x++) begin
        cur_a[x] = int'(tbl[v].a[x]);
        cur_b[x] = int'(tbl[v].b[x]);
      end
      for (int x = 0; x < MM; x++) exp_c[x] = int'(tbl[v].c[x]);
      run_job(int'(tbl[v].mode), 1'b0);
    end

    for (int x = 0; x < MN; x++) begin
      cur_a[x] = int'(tbl[0].a[x]);
      cur_b[x] = int'(tbl[0].b[x]);
    end
    for (int x = 0; x < MM; x++) exp_c[x] = int'(tbl[0].c[x]);
    run_job(0, 1'b1);
    run_job(0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int x = 0; x < MN; x++) begin
        cur_a[x] = int'($urandom_range(0, 255));
        cur_b[x] = int'($urandom_range(0, 255));
      end
      ref_matmul();
      run_job(2, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Control FSM for the matrix-multiply datapath. Accepts a start command, streams operand A (M×N) then operand B (N×M) into the datapath's two operand memories through a valid/ready handshake, then sequences every multiply-accumulate, clear and write-back that produces the M×M result matrix. It drives every enable, address and accumulator-control input of the datapath. The operand byte stream goes straight to the datapath `data_in`, not through this block.

## Interface
- `M`, default 8: rows of A, columns of B, and result dimension.
- `N`, default 8: columns of A and rows of B, which is the MAC depth.
- `ADDR_W`, default 16: width of each address output. Must be ≥ clog2(max(M·N, M·M)).
- `SHIFT`, default 2'b00: constant value driven on `shift_cnt`.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: begins a job. Sampled only in IDLE.
- `in_valid` in 1: upstream operand word is present.
- `in_ready` out 1: the controller accepts the word this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the job completes.
- `m1EN`, `m1rEN`, `m1wEN` out 1 each: mat1 enable, read and write strobes.
- `m2EN`, `m2rEN`, `m2wEN` out 1 each: mat2 enable, read and write strobes.
- `m3EN`, `m3rEN`, `m3wEN` out 1 each: mat3 enable, read and write strobes.
- `mult_ld` out 1: accumulator load.
- `mult_rst` out 1: accumulator clear.
- `addr1`, `addr2`, `addr3` out ADDR_W each: memory addresses.
- `shift_cnt` out 2: constant `SHIFT`.
- `out_valid` out 1: readback data valid on datapath `data_out`. Exists only with the macro below.

## Operation
- Storage is row-major in all three memories:
  - A[i][k] is at `addr1 = i·N+k`.
  - B[k][j] is at `addr2 = k·M+j`.
  - C[i][j] is at `addr3 = i·M+j`.
- Memory reads are synchronous. Data is valid on `out1`/`out2` the cycle after `rEN`.
- IDLE:
  - All strobes are 0.
  - `start` → LOAD_A, with the load counter cleared.
- LOAD_A:
  - `in_ready` = 1.
  - On `in_valid`: `m1EN` = `m1wEN` = 1, `addr1` = load counter, and the counter increments.
  - After the M·N-th accepted word → LOAD_B, with the counter cleared.
  - A cycle with `in_valid` = 0 writes nothing and holds the counter.
- LOAD_B: same as LOAD_A using mat2 and M·N words, then → CLR with i = j = k = 0.
- CLR:
  - `mult_rst` = 1 for one cycle → MAC.
- MAC:
  - Lasts N cycles, with k = 0..N-1.
  - Each cycle asserts `m1EN`, `m1rEN`, `m2EN` and `m2rEN`, with `addr1` = i·N+k and `addr2` = k·M+j.
  - After k = N-1 → TAIL.
- `mult_ld` is the read-issue strobe delayed by one register. It is high in MAC cycles k = 1..N-1 and in TAIL.
- TAIL: one cycle. The last product is accumulated. → WB.
- WB:
  - `m3EN` = `m3wEN` = 1, `addr3` = i·M+j, for one cycle.
  - Then advance j. When j wraps, j = 0 and i increments.
  - → CLR, or → DONE after C[M-1][M-1].
- DONE: `done` = 1 for one cycle → IDLE.
- Address arithmetic is unsigned and zero-extended to ADDR_W. Counters never exceed M-1, N-1, or M·N-1 respectively.

## Timing
- Reset:
  - While `rst` = 0 at a rising edge, the state becomes IDLE and all counters 0.
  - All outputs are 0 except `shift_cnt` = SHIFT.
  - Reset during any state, including mid-load or mid-MAC, aborts the job. No `done` is produced. Memory contents are undefined for the aborted job.
- `start` latency: start asserted in cycle t gives `in_ready` = 1 in cycle t+1.
- Load phase: 2·M·N accepted handshakes. Minimum is 2·M·N cycles with `in_valid` held high.
- Compute phase: N+3 cycles per result element, M·M·(N+3) cycles in total.
- `done` follows the last WB by exactly one cycle.
- `start` while busy is ignored.
- `start` in the same cycle as `done` is ignored. A new job needs `start` in a later IDLE cycle.
- `in_valid` outside LOAD_A/LOAD_B is ignored, and `in_ready` stays 0.

## Configuration
- `MATMUL_CTRL_READBACK_EN`:
  - **Defined:** after the last WB the FSM enters READ instead of DONE.
    - READ issues M·M consecutive reads of mat3: `m3EN` = `m3rEN` = 1, `addr3` = 0..M·M-1.
    - `out_valid` is high one cycle after each read and marks valid `data_out`.
    - DONE follows the cycle after the last `out_valid`.
  - **Undefined:**
    - The READ state and the `out_valid` port are absent.
    - `m3rEN` is tied 0.
    - The FSM goes from the last WB directly to DONE.

## Test plan
- Reset mid-MAC:
  - Stimulus: `rst` = 0 during MAC of element (1,0).
  - Response: next cycle IDLE, all strobes 0, `busy` = 0, no `done`.
  - Stimulus: then a fresh start and load.
  - Response: correct results.
- Basic 2×2 job (M = N = 2, with datapath attached):
  - Stimulus: `start`, then stream A = 1,2,3,4 and B = 5,6,7,8 with `in_valid` held high.
  - Response: mat3 writes 19,22,43,50 at addr3 0..3.
  - Response: `done` exactly 8 + 20 cycles after the first accepted word.
- Load backpressure:
  - Stimulus: toggle `in_valid` 1,0,1,0… during load.
  - Response: only cycles with `in_valid` = 1 produce writes, `addr1`/`addr2` advance by 1 per accepted word, and the results match the contiguous-stream case.
- MAC strobe alignment (M = N = 8):
  - Response: per element, `mult_rst` is one pulse.
  - Response: `mult_ld` is high exactly 8 cycles, each one cycle after an rEN.
  - Response: WB addr3 sequence is 0,1,…,63.
- Ignored `start`:
  - Stimulus: `start` pulsed during LOAD_B and during MAC.
  - Response: no state change and no counter change.
- Readback (with `MATMUL_CTRL_READBACK_EN`, 2×2 job above):
  - Response: `out_valid` pulses 4 times with `data_out` = 19,22,43,50.
  - Response: `done` the cycle after the last `out_valid`.
